// File: rtl/decode_issue.sv
// decode_issue: decode-and-issue stage between fetch and execute.
// One D register holds the instruction being decoded; the EX register holds
// the operand-complete micro-op presented to execute. A 16-bit scoreboard of
// pending destination writes blocks RAW/WAW hazards until writeback clears them.
module decode_issue (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_valid,
    output logic        if_ready,
    input  logic [15:0] if_instr,
    output logic [3:0]  reg_read_addr_1,
    output logic [3:0]  reg_read_addr_2,
    input  logic [15:0] reg_read_data_1,
    input  logic [15:0] reg_read_data_2,
    output logic        ex_valid,
    input  logic        ex_ready,
    output logic [3:0]  ex_opcode,
    output logic [3:0]  ex_dest,
    output logic        ex_writes,
    output logic [15:0] ex_op_a,
    output logic [15:0] ex_op_b,
    input  logic        wb_valid,
    input  logic [3:0]  wb_dest,
    output logic [15:0] busy_mask,
    output logic        illegal_op,
    output logic [15:0] stall_count
);

    // D stage
    logic        r_d_valid;
    logic [15:0] r_d_instr;

    // EX output register
    logic        r_ex_valid;
    logic [3:0]  r_ex_opcode;
    logic [3:0]  r_ex_dest;
    logic        r_ex_writes;
    logic [15:0] r_ex_op_a;
    logic [15:0] r_ex_op_b;

    // Scoreboard and status
    logic [15:0] r_busy;
    logic        r_illegal;
    logic [15:0] r_stall_count;

    // Decode of the D register
    logic [3:0]  w_opcode;
    logic [3:0]  w_rd;
    logic [3:0]  w_rs1;
    logic [3:0]  w_rs2;
    logic        w_is_rtype;
    logic        w_is_addi;
    logic        w_is_illegal;
    logic        w_uses_rs1;
    logic        w_uses_rs2;
    logic        w_writes;
    logic [15:0] w_imm_sext;
    logic        w_hazard;
    logic        w_issue;
    logic        w_accept;
    logic [15:0] w_busy_set;
    logic [15:0] w_busy_clr;

    assign w_opcode     = r_d_instr[15:12];
    assign w_rd         = r_d_instr[11:8];
    assign w_rs1        = r_d_instr[7:4];
    assign w_rs2        = r_d_instr[3:0];

    // 0x1..0x7 R-type, 0x8 ADDI, 0x9..0xF illegal, 0x0 NOP
    assign w_is_rtype   = ~w_opcode[3] & (w_opcode[2:0] != 3'd0);
    assign w_is_addi    = (w_opcode == 4'h8);
    assign w_is_illegal = w_opcode[3] & (w_opcode[2:0] != 3'd0);

    assign w_uses_rs1   = w_is_rtype | w_is_addi;
    assign w_uses_rs2   = w_is_rtype;
    assign w_writes     = w_is_rtype | w_is_addi;
    assign w_imm_sext   = {{12{r_d_instr[3]}}, r_d_instr[3:0]};

    // Only the registered scoreboard is consulted; a same-cycle writeback
    // does not bypass into the hazard check.
    assign w_hazard = (w_uses_rs1 & r_busy[w_rs1]) |
                      (w_uses_rs2 & r_busy[w_rs2]) |
                      (w_writes   & r_busy[w_rd]);

    assign w_issue  = r_d_valid & ~w_hazard & (~r_ex_valid | ex_ready);
    assign if_ready = ~rst & (~r_d_valid | w_issue);
    assign w_accept = if_valid & if_ready;

    assign reg_read_addr_1 = r_d_valid ? w_rs1 : 4'h0;
    assign reg_read_addr_2 = r_d_valid ? w_rs2 : 4'h0;

    assign ex_valid    = r_ex_valid;
    assign ex_opcode   = r_ex_opcode;
    assign ex_dest     = r_ex_dest;
    assign ex_writes   = r_ex_writes;
    assign ex_op_a     = r_ex_op_a;
    assign ex_op_b     = r_ex_op_b;
    assign busy_mask   = r_busy;
    assign illegal_op  = r_illegal;
    assign stall_count = r_stall_count;

    // D register: load on accept, empty on issue, hold while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            r_d_valid <= 1'b0;
            r_d_instr <= 16'h0000;
        end else if (w_accept) begin
            r_d_valid <= 1'b1;
            r_d_instr <= if_instr;
        end else if (w_issue) begin
            r_d_valid <= 1'b0;
        end
    end

    // EX register: capture decoded micro-op plus register file data on issue
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_valid  <= 1'b0;
            r_ex_opcode <= 4'h0;
            r_ex_dest   <= 4'h0;
            r_ex_writes <= 1'b0;
            r_ex_op_a   <= 16'h0000;
            r_ex_op_b   <= 16'h0000;
        end else if (w_issue) begin
            r_ex_valid  <= 1'b1;
            r_ex_opcode <= w_is_illegal ? 4'h0 : w_opcode;
            r_ex_dest   <= w_rd;
            r_ex_writes <= w_writes;
            r_ex_op_a   <= w_uses_rs1 ? reg_read_data_1 : 16'h0000;
            r_ex_op_b   <= w_is_addi  ? w_imm_sext :
                           w_uses_rs2 ? reg_read_data_2 : 16'h0000;
        end else if (ex_ready) begin
            r_ex_valid  <= 1'b0;
        end
    end

    // Scoreboard: one bit per architectural register, set beats clear
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_busy
            assign w_busy_set[gi] = w_issue & w_writes & (w_rd == 4'(gi));
            assign w_busy_clr[gi] = wb_valid & (wb_dest == 4'(gi));

            // Per-register pending-write flag
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_busy[gi] <= 1'b0;
                end else if (w_busy_set[gi]) begin
                    r_busy[gi] <= 1'b1;
                end else if (w_busy_clr[gi]) begin
                    r_busy[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    // Saturating count of cycles lost to scoreboard hazards
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_count <= 16'h0000;
        end else if (r_d_valid & w_hazard & (r_stall_count != 16'hFFFF)) begin
            r_stall_count <= r_stall_count + 16'h0001;
        end
    end

    // Sticky flag raised when an illegal opcode leaves decode
    always_ff @(posedge clk) begin
        if (rst) begin
            r_illegal <= 1'b0;
        end else if (w_issue & w_is_illegal) begin
            r_illegal <= 1'b1;
        end
    end

endmodule

// File: tb/tb_decode_issue.sv
// Testbench for decode_issue: directed scenarios followed by randomized
// streaming, checked against an instruction-level model of the program.
module tb_decode_issue;

    logic        clk;
    logic        rst;
    logic        if_valid;
    logic        if_ready;
    logic [15:0] if_instr;
    logic [3:0]  reg_read_addr_1;
    logic [3:0]  reg_read_addr_2;
    logic [15:0] reg_read_data_1;
    logic [15:0] reg_read_data_2;
    logic        ex_valid;
    logic        ex_ready;
    logic [3:0]  ex_opcode;
    logic [3:0]  ex_dest;
    logic        ex_writes;
    logic [15:0] ex_op_a;
    logic [15:0] ex_op_b;
    logic        wb_valid;
    logic [3:0]  wb_dest;
    logic [15:0] busy_mask;
    logic        illegal_op;
    logic [15:0] stall_count;

    decode_issue dut (
        .clk             (clk),
        .rst             (rst),
        .if_valid        (if_valid),
        .if_ready        (if_ready),
        .if_instr        (if_instr),
        .reg_read_addr_1 (reg_read_addr_1),
        .reg_read_addr_2 (reg_read_addr_2),
        .reg_read_data_1 (reg_read_data_1),
        .reg_read_data_2 (reg_read_data_2),
        .ex_valid        (ex_valid),
        .ex_ready        (ex_ready),
        .ex_opcode       (ex_opcode),
        .ex_dest         (ex_dest),
        .ex_writes       (ex_writes),
        .ex_op_a         (ex_op_a),
        .ex_op_b         (ex_op_b),
        .wb_valid        (wb_valid),
        .wb_dest         (wb_dest),
        .busy_mask       (busy_mask),
        .illegal_op      (illegal_op),
        .stall_count     (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file contents as seen by the DUT read ports
    logic [15:0] rf [16];
    assign reg_read_data_1 = rf[reg_read_addr_1];
    assign reg_read_data_2 = rf[reg_read_addr_2];

    typedef struct {
        logic [3:0]  op;
        logic [3:0]  dest;
        logic        wr;
        logic        ua;
        logic        ub;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
    } uop_t;

    typedef struct {
        logic [3:0]  dest;
        logic [15:0] val;
        int          due;
    } pend_t;

    logic [15:0] arch [16];   // program-order architectural state
    uop_t        exp_q [$];   // accepted, not yet consumed by execute
    pend_t       pend  [$];   // consumed, awaiting writeback
    bit          ex_seen [0:1023];
    bit          illegal_seen;
    int          cyc;
    int          n_checks;
    int          n_fail;
    bit          auto_wb;
    bit          acc_flag;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    // Architectural effect of accepting one instruction, in program order
    task automatic model_accept(input logic [15:0] ins);
        uop_t e;
        logic [3:0] op;
        op     = ins[15:12];
        e.op   = (op <= 4'h8) ? op : 4'h0;
        e.wr   = (op >= 4'h1) && (op <= 4'h8);
        e.ua   = e.wr;
        e.ub   = e.wr;
        e.dest = ins[11:8];
        e.a    = arch[ins[7:4]];
        e.b    = (op == 4'h8) ? {{12{ins[3]}}, ins[3:0]} : arch[ins[3:0]];
        e.res  = 16'($urandom);
        if (e.wr) arch[ins[11:8]] = e.res;
        if (op > 4'h8) illegal_seen = 1'b1;
        exp_q.push_back(e);
    endtask

    // One clock cycle: optional auto writeback, output checks, handshakes
    task automatic tick();
        uop_t  e;
        pend_t p;
        if (auto_wb) begin
            wb_valid = 1'b0;
            if (pend.size() > 0 && pend[0].due <= cyc && ($urandom % 2) == 0) begin
                wb_valid = 1'b1;
                wb_dest  = pend[0].dest;
                rf[pend[0].dest] = pend[0].val;
                void'(pend.pop_front());
            end
        end
        #1;
        if (ex_valid) begin
            if (cyc < 1024) ex_seen[cyc] = 1'b1;
            if (exp_q.size() == 0) begin
                check_val("ex_unexpected", 32'(ex_valid), 32'd0);
            end else begin
                e = exp_q[0];
                check_val("ex_opcode", 32'(ex_opcode), 32'(e.op));
                check_val("ex_writes", 32'(ex_writes), 32'(e.wr));
                if (e.wr) check_val("ex_dest", 32'(ex_dest), 32'(e.dest));
                if (e.ua) check_val("ex_op_a", 32'(ex_op_a), 32'(e.a));
                if (e.ub) check_val("ex_op_b", 32'(ex_op_b), 32'(e.b));
                if (ex_ready) begin
                    void'(exp_q.pop_front());
                    if (e.wr) begin
                        p.dest = e.dest;
                        p.val  = e.res;
                        p.due  = cyc + $urandom_range(0, 4);
                        pend.push_back(p);
                    end
                end
            end
        end
        acc_flag = if_valid && if_ready;
        if (acc_flag) model_accept(if_instr);
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    // Write back the oldest pending destination in the next cycle
    task automatic do_wb();
        if (pend.size() == 0) begin
            check_val("wb_pending", 32'd0, 32'd1);
        end else begin
            wb_valid = 1'b1;
            wb_dest  = pend[0].dest;
            rf[pend[0].dest] = pend[0].val;
            void'(pend.pop_front());
            tick();
            wb_valid = 1'b0;
        end
    endtask

    // Let everything in flight issue, execute and write back
    task automatic drain();
        int n;
        bit save;
        save     = auto_wb;
        auto_wb  = 1'b1;
        if_valid = 1'b0;
        ex_ready = 1'b1;
        n = 0;
        while ((exp_q.size() > 0 || pend.size() > 0) && n < 300) begin
            tick();
            n++;
        end
        wb_valid = 1'b0;
        auto_wb  = save;
        check_val("drain_left", 32'(exp_q.size() + pend.size()), 32'd0);
        check_val("drain_busy", 32'(busy_mask), 32'd0);
    endtask

    function automatic logic [15:0] rand_instr();
        int r;
        bit wide;
        logic [3:0] op, rd, s1, s2;
        r = $urandom_range(0, 15);
        if (r == 0)       op = 4'h0;
        else if (r <= 9)  op = 4'($urandom_range(1, 7));
        else if (r <= 12) op = 4'h8;
        else if (r == 13) op = 4'($urandom_range(9, 15));
        else              op = 4'($urandom_range(1, 7));
        wide = ($urandom % 8) == 0;
        rd = wide ? 4'($urandom % 16) : 4'($urandom % 6);
        s1 = wide ? 4'($urandom % 16) : 4'($urandom % 6);
        s2 = 4'($urandom % 16);
        if (op != 4'h8 && !wide) s2 = 4'($urandom % 6);
        return {op, rd, s1, s2};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    logic [15:0] bp_list [4];
    logic [15:0] r1val;
    int          t0;
    int          idx;

    initial begin
        n_checks = 0; n_fail = 0; cyc = 0;
        auto_wb = 1'b0; illegal_seen = 1'b0; acc_flag = 1'b0;
        rst = 1'b1; if_valid = 1'b0; if_instr = 16'h0000;
        ex_ready = 1'b1; wb_valid = 1'b0; wb_dest = 4'h0;
        for (int i = 0; i < 16; i++) begin
            rf[i]   = 16'($urandom);
            arch[i] = rf[i];
        end
        @(negedge clk);
        tick();
        tick();

        // Reset state
        check_val("rst_if_ready", 32'(if_ready), 32'd0);
        check_val("rst_ex_valid", 32'(ex_valid), 32'd0);
        check_val("rst_ex_op_a", 32'(ex_op_a), 32'd0);
        check_val("rst_busy", 32'(busy_mask), 32'd0);
        check_val("rst_illegal", 32'(illegal_op), 32'd0);
        check_val("rst_stall", 32'(stall_count), 32'd0);
        rst = 1'b0;
        #1;
        check_val("post_rst_if_ready", 32'(if_ready), 32'd1);

        // Stream NOP, 0x1123, 0x1456 back to back
        t0 = cyc;
        if_valid = 1'b1;
        if_instr = 16'h0000; tick(); check_val("t1_acc0", 32'(acc_flag), 32'd1);
        if_instr = 16'h1123; tick(); check_val("t1_acc1", 32'(acc_flag), 32'd1);
        if_instr = 16'h1456; tick(); check_val("t1_acc2", 32'(acc_flag), 32'd1);
        if_valid = 1'b0;
        tick(); tick();
        check_val("t1_ex_early", 32'(ex_seen[t0 + 1]), 32'd0);
        check_val("t1_ex_n2", 32'(ex_seen[t0 + 2]), 32'd1);
        check_val("t1_ex_n3", 32'(ex_seen[t0 + 3]), 32'd1);
        check_val("t1_ex_n4", 32'(ex_seen[t0 + 4]), 32'd1);
        check_val("t1_ex_done", 32'(ex_valid), 32'd0);
        check_val("t1_busy", 32'(busy_mask), 32'h0012);
        check_val("t1_stall", 32'(stall_count), 32'd0);
        drain();

        // RAW: 0x1510 waits for writeback of r1
        t0 = cyc;
        if_valid = 1'b1;
        if_instr = 16'h1123; tick();
        if_instr = 16'h1510; tick();
        if_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        r1val = pend[0].val;
        do_wb();
        tick();
        check_val("t2_no_early_issue", 32'(ex_seen[t0 + 8]), 32'd0);
        check_val("t2_ex_valid", 32'(ex_valid), 32'd1);
        check_val("t2_op_a_new_r1", 32'(ex_op_a), 32'(r1val));
        check_val("t2_stall_count", 32'(stall_count), 32'd6);
        drain();

        // ADDI with negative immediate
        rf[2] = 16'h0666; arch[2] = 16'h0666;
        if_valid = 1'b1; if_instr = 16'h832F; tick();
        if_valid = 1'b0; tick();
        #1;
        check_val("t3_ex_valid", 32'(ex_valid), 32'd1);
        check_val("t3_op_a", 32'(ex_op_a), 32'h0666);
        check_val("t3_op_b", 32'(ex_op_b), 32'hFFFF);
        check_val("t3_dest", 32'(ex_dest), 32'd3);
        check_val("t3_writes", 32'(ex_writes), 32'd1);
        drain();

        // Backpressure: execute stalls for 4 cycles while fetch keeps offering
        bp_list[0] = 16'h1612; bp_list[1] = 16'h1734;
        bp_list[2] = 16'h1801; bp_list[3] = 16'h1902;
        idx = 0;
        ex_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if_valid = 1'b1; if_instr = bp_list[idx]; tick();
            if (acc_flag) idx++;
        end
        for (int k = 0; k < 4; k++) begin
            if_valid = 1'b1; if_instr = bp_list[idx];
            #1;
            check_val("t4_if_ready_low", 32'(if_ready), 32'd0);
            check_val("t4_ex_held", 32'(ex_valid), 32'd1);
            check_val("t4_parked_rs1", 32'(reg_read_addr_1), 32'd3);
            check_val("t4_parked_rs2", 32'(reg_read_addr_2), 32'd4);
            tick();
            if (acc_flag) idx++;
        end
        ex_ready = 1'b1;
        for (int k = 0; k < 20 && idx < 4; k++) begin
            if_valid = 1'b1; if_instr = bp_list[idx]; tick();
            if (acc_flag) idx++;
        end
        check_val("t4_all_accepted", 32'(idx), 32'd4);
        drain();

        // Illegal opcode, then reset in the middle of a hazard stall
        if_valid = 1'b1; if_instr = 16'hA000; tick();
        if_valid = 1'b0; tick();
        #1;
        check_val("t5_ex_valid", 32'(ex_valid), 32'd1);
        check_val("t5_opcode", 32'(ex_opcode), 32'd0);
        check_val("t5_writes", 32'(ex_writes), 32'd0);
        tick();
        check_val("t5_illegal_set", 32'(illegal_op), 32'd1);
        if_valid = 1'b1; if_instr = 16'h1123; tick();
        if_instr = 16'h1110; tick();
        if_valid = 1'b0;
        tick(); tick(); tick();
        check_val("t5_busy_stall", 32'(busy_mask), 32'h0002);
        check_val("t5_illegal_sticky", 32'(illegal_op), 32'd1);
        rst = 1'b1; ex_ready = 1'b0;
        #1;
        check_val("t5_rst_if_ready", 32'(if_ready), 32'd0);
        tick();
        rst = 1'b0; ex_ready = 1'b1;
        exp_q.delete();
        check_val("t5_rst_busy", 32'(busy_mask), 32'd0);
        check_val("t5_rst_illegal", 32'(illegal_op), 32'd0);
        check_val("t5_rst_ex_valid", 32'(ex_valid), 32'd0);
        check_val("t5_rst_stall", 32'(stall_count), 32'd0);
        check_val("t5_rst_raddr", 32'(reg_read_addr_1), 32'd0);
        do_wb();   // stale writeback of r1 after reset
        check_val("t5_stale_wb", 32'(busy_mask), 32'd0);
        pend.delete();
        exp_q.delete();
        for (int i = 0; i < 16; i++) arch[i] = rf[i];
        illegal_seen = 1'b0;

        // Randomized streaming with random backpressure and writeback delay
        auto_wb = 1'b1;
        if_valid = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            ex_ready = ($urandom % 4) != 0;
            if (!if_valid && ($urandom % 4) != 0) begin
                if_valid = 1'b1;
                if_instr = rand_instr();
            end
            tick();
            if (acc_flag) if_valid = 1'b0;
        end
        drain();
        check_val("rand_illegal_flag", 32'(illegal_op), 32'(illegal_seen));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
